// File: rtl/uart_pkg.sv
// Shared UART types and command byte constants for the receiver and the
// downstream echo/command FSMs.
package uart_pkg;

  localparam int UART_DATA_BITS = 8;

  localparam logic [7:0] CMD_ECHO_OFF = 8'h65;
  localparam logic [7:0] CMD_ECHO_ON  = 8'h45;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    STOP,
    BREAK
  } rx_state_t;

  function automatic logic majority3(input logic a, input logic b, input logic c);
    return (a & b) | (a & c) | (b & c);
  endfunction

endpackage

// File: rtl/uart_rx_cmd_if.sv
// Serial line plus received-byte outputs of the UART command receiver.
interface uart_rx_cmd_if;
  import uart_pkg::*;

  logic                      Rx;
  logic [UART_DATA_BITS-1:0] Data;
  logic                      DataValid;
  logic                      FrameError;
  logic                      Busy;

  modport master (input Rx, output Data, output DataValid, output FrameError, output Busy);
  modport slave  (output Rx, input Data, input DataValid, input FrameError, input Busy);

endinterface

// File: rtl/uart_rx_sync.sv
// Two-flop synchroniser for the Rx pin plus a delay flop for falling-edge
// detection; flops reset high so reset release cannot fake a start edge.
module uart_rx_sync
  import uart_pkg::*;
(
  input  logic Clock,
  input  logic Reset,
  input  logic rx,
  output logic rx_s,
  output logic fall
);

  logic s1, s2, s3;
  logic v1, v2;
  logic armed;

  // armed only after a genuinely sampled high, so a line held low across
  // reset release must go high and low again before it can start a frame
  always_ff @(posedge Clock) begin
    if (Reset) begin
      s1    <= 1'b1;
      s2    <= 1'b1;
      s3    <= 1'b1;
      v1    <= 1'b0;
      v2    <= 1'b0;
      armed <= 1'b0;
    end else begin
      s1    <= rx;
      s2    <= s1;
      s3    <= s2;
      v1    <= 1'b1;
      v2    <= v1;
      armed <= armed | (v2 & s2);
    end
  end

  assign rx_s = s2;
  assign fall = armed & s3 & ~s2;

endmodule

// File: rtl/uart_rx_cmd.sv
// 8N1 UART receiver producing command bytes; mid-bit 3-sample majority vote,
// false-start rejection and framing-error detection with break hold-off.
module uart_rx_cmd
  import uart_pkg::*;
#(
  parameter  int CLKS_PER_BIT = 868,
  localparam int CNT_W        = $clog2(CLKS_PER_BIT)
) (
  input  logic          Clock,
  input  logic          Reset,
  uart_rx_cmd_if.master rx_if
);

  localparam logic [CNT_W-1:0] LAST   = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [CNT_W-1:0] MID    = CNT_W'(CLKS_PER_BIT / 2);
  localparam logic [CNT_W-1:0] MID_M1 = CNT_W'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CNT_W-1:0] MID_P1 = CNT_W'(CLKS_PER_BIT / 2 + 1);
  localparam logic [2:0]       LAST_BIT = 3'(UART_DATA_BITS - 1);

  logic                      rx_s, fall;
  rx_state_t                 state;
  logic [CNT_W-1:0]          cnt;
  logic                      samp_a, samp_b;
  logic [2:0]                bit_idx;
  logic [UART_DATA_BITS-1:0] shreg;
  logic [UART_DATA_BITS-1:0] data_q;
  logic                      valid_q, ferr_q, busy_q;
  logic                      decide, vote;

  uart_rx_sync u_sync (
    .Clock (Clock),
    .Reset (Reset),
    .rx    (rx_if.Rx),
    .rx_s  (rx_s),
    .fall  (fall)
  );

  assign decide = (cnt == MID_P1);
  assign vote   = majority3(samp_a, samp_b, rx_s);

  always_ff @(posedge Clock) begin
    if (Reset) begin
      state   <= IDLE;
      cnt     <= '0;
      samp_a  <= 1'b1;
      samp_b  <= 1'b1;
      bit_idx <= '0;
      shreg   <= '0;
      data_q  <= '0;
      valid_q <= 1'b0;
      ferr_q  <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      valid_q <= 1'b0;
      ferr_q  <= 1'b0;

      if (state == IDLE || cnt == LAST) cnt <= '0;
      else                              cnt <= cnt + 1'b1;

      if (cnt == MID_M1) samp_a <= rx_s;
      if (cnt == MID)    samp_b <= rx_s;

      case (state)
        IDLE: begin
          if (fall) begin
            state  <= START;
            busy_q <= 1'b1;
          end
        end
        START: begin
          if (decide) begin
            if (vote) begin
              state  <= IDLE;
              busy_q <= 1'b0;
            end else begin
              state   <= DATA;
              bit_idx <= '0;
            end
          end
        end
        DATA: begin
          if (decide) begin
            shreg <= {vote, shreg[UART_DATA_BITS-1:1]};
            if (bit_idx == LAST_BIT) state   <= STOP;
            else                     bit_idx <= bit_idx + 3'd1;
          end
        end
        STOP: begin
          // leaving at mid-stop-bit keeps IDLE ready for a back-to-back start
          if (decide) begin
            if (vote) begin
              data_q  <= shreg;
              valid_q <= 1'b1;
              state   <= IDLE;
              busy_q  <= 1'b0;
            end else begin
              ferr_q <= 1'b1;
              state  <= BREAK;
            end
          end
        end
        BREAK: begin
          if (rx_s) begin
            state  <= IDLE;
            busy_q <= 1'b0;
          end
        end
        default: begin
          state  <= IDLE;
          busy_q <= 1'b0;
        end
      endcase
    end
  end

  assign rx_if.Data       = data_q;
  assign rx_if.DataValid  = valid_q;
  assign rx_if.FrameError = ferr_q;
  assign rx_if.Busy       = busy_q;

endmodule

// File: tb/tb_uart_rx_cmd.sv
// Scoreboard bench for uart_rx_cmd at 16 clocks per bit: expected strobes are
// queued as frames are driven and matched when DataValid/FrameError fire.
module tb_uart_rx_cmd;
  import uart_pkg::*;

  localparam int CPB = 16;
  localparam int LAT = 9 * CPB + CPB / 2 + 1 + 1;

  typedef struct {
    logic       ferr;
    logic [7:0] data;
  } exp_t;

  logic Clock = 1'b0;
  logic Reset = 1'b1;

  uart_rx_cmd_if rx_if ();

  uart_rx_cmd #(.CLKS_PER_BIT(CPB)) dut (
    .Clock (Clock),
    .Reset (Reset),
    .rx_if (rx_if)
  );

  always #5 Clock = ~Clock;

  exp_t exp_q[$];
  int   n_checks = 0;
  int   n_errors = 0;
  int   cyc      = 0;
  int   t_busy   = 0;
  int   busy_len = 0;
  int   n_busy   = 0;
  logic busy_d   = 1'b0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  always @(posedge Clock) cyc++;

  // strobe monitor: cycles are counted from the first cycle Busy is high
  always @(negedge Clock) begin
    if (!Reset) begin
      if (rx_if.Busy && !busy_d) begin
        t_busy = cyc;
        n_busy++;
      end
      if (!rx_if.Busy && busy_d) busy_len = cyc - t_busy;
      busy_d = rx_if.Busy;
      if (rx_if.DataValid || rx_if.FrameError) begin
        chk("strobe_excl", 32'(rx_if.DataValid & rx_if.FrameError), 32'd0);
        if (exp_q.size() == 0) begin
          chk("unexpected_strobe", {30'd0, rx_if.DataValid, rx_if.FrameError}, 32'd0);
        end else begin
          exp_t e;
          e = exp_q.pop_front();
          chk("strobe_kind", 32'(rx_if.FrameError), 32'(e.ferr));
          chk("strobe_data", 32'(rx_if.Data), 32'(e.data));
          chk("strobe_latency", 32'(cyc - t_busy), 32'(LAT));
        end
      end
    end else begin
      busy_d = 1'b0;
    end
  end

  task automatic drive(input logic v, input int n);
    rx_if.Rx = v;
    repeat (n) @(negedge Clock);
  endtask

  task automatic send_frame(input logic [7:0] b, input logic stop_v, input int stop_len);
    drive(1'b0, CPB);
    for (int i = 0; i < 8; i++) drive(b[i], CPB);
    drive(stop_v, stop_len);
  endtask

  initial begin
    int nb;
    rx_if.Rx = 1'b1;
    Reset    = 1'b1;
    repeat (4) @(negedge Clock);
    chk("rst_data",  32'(rx_if.Data), 32'h00);
    chk("rst_valid", 32'(rx_if.DataValid), 32'd0);
    chk("rst_ferr",  32'(rx_if.FrameError), 32'd0);
    chk("rst_busy",  32'(rx_if.Busy), 32'd0);
    Reset = 1'b0;
    drive(1'b1, 10);

    // good frame
    exp_q.push_back('{ferr: 1'b0, data: CMD_ECHO_OFF});
    send_frame(CMD_ECHO_OFF, 1'b1, CPB);
    drive(1'b1, 10);
    chk("t1_drained", 32'(exp_q.size()), 32'd0);

    // false start: low for 4 cycles
    nb = n_busy;
    drive(1'b0, 4);
    drive(1'b1, 40);
    chk("t2_start_seen", 32'(n_busy - nb), 32'd1);
    chk("t2_busy_len", 32'(busy_len), 32'd10);
    chk("t2_data_held", 32'(rx_if.Data), 32'h65);

    // framing error with a 2-period low stop bit
    exp_q.push_back('{ferr: 1'b1, data: 8'h65});
    send_frame(CMD_ECHO_ON, 1'b0, 2 * CPB - 1);
    chk("t3_busy_in_break", 32'(rx_if.Busy), 32'd1);
    drive(1'b0, 1);
    drive(1'b1, 5);
    chk("t3_busy_released", 32'(rx_if.Busy), 32'd0);
    chk("t3_data_held", 32'(rx_if.Data), 32'h65);
    drive(1'b1, 10);

    // back-to-back frames, single-period stop bits
    exp_q.push_back('{ferr: 1'b0, data: CMD_ECHO_ON});
    exp_q.push_back('{ferr: 1'b0, data: CMD_ECHO_OFF});
    send_frame(CMD_ECHO_ON, 1'b1, CPB);
    send_frame(CMD_ECHO_OFF, 1'b1, CPB);
    drive(1'b1, 10);
    chk("t4_drained", 32'(exp_q.size()), 32'd0);

    // one-cycle glitch at mid-bit 3 of 0x00 must be voted out
    exp_q.push_back('{ferr: 1'b0, data: 8'h00});
    drive(1'b0, CPB);
    drive(1'b0, 3 * CPB);
    drive(1'b0, CPB / 2 + 1);
    drive(1'b1, 1);
    drive(1'b0, CPB / 2 - 2);
    drive(1'b0, 4 * CPB);
    drive(1'b1, CPB);
    drive(1'b1, 10);
    chk("t5_drained", 32'(exp_q.size()), 32'd0);
    chk("t5_data", 32'(rx_if.Data), 32'h00);

    // load a nonzero byte, then reset in the middle of bit 4 of the next frame
    exp_q.push_back('{ferr: 1'b0, data: CMD_ECHO_ON});
    send_frame(CMD_ECHO_ON, 1'b1, CPB);
    drive(1'b1, 10);
    drive(1'b0, CPB);
    drive(1'b1, CPB);
    drive(1'b0, CPB);
    drive(1'b1, CPB);
    drive(1'b0, CPB);
    drive(1'b0, CPB / 2);
    Reset = 1'b1;
    @(negedge Clock);
    chk("t6_rst_data",  32'(rx_if.Data), 32'h00);
    chk("t6_rst_valid", 32'(rx_if.DataValid), 32'd0);
    chk("t6_rst_ferr",  32'(rx_if.FrameError), 32'd0);
    chk("t6_rst_busy",  32'(rx_if.Busy), 32'd0);
    Reset = 1'b0;
    drive(1'b0, 40);
    chk("t6_held_low_busy", 32'(rx_if.Busy), 32'd0);
    drive(1'b1, 2 * CPB);
    exp_q.push_back('{ferr: 1'b0, data: CMD_ECHO_OFF});
    send_frame(CMD_ECHO_OFF, 1'b1, CPB);
    drive(1'b1, 40);
    chk("t6_data", 32'(rx_if.Data), 32'h65);
    chk("sb_empty", 32'(exp_q.size()), 32'd0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
